line_buf_window_gen: RTL and testbench
======================================

Name: line_buf_window_gen

Overview:
- Streaming controller on the pixel side of the kernel-row SRAM line buffer (sram_array_kN).
- Accepts a raster pixel stream and generates that array's a/wen/ren/d controls, rotating the write bank per image row.
- Combines the array's reordered K-1 previous-row read data with the current pixel into a KxK sliding window for the conv datapath.
- Pulses frame completion.

Parameters:
KER_SIZE, 3, kernel size K; legal values 2, 3, 5, 7.
DW, 32, pixel width in bits.
IMG_W, 32, image width in pixels; also the SRAM depth NW; must be >= K.
IMG_H, 32, image height in rows; must be >= K.
AW, $clog2(IMG_W), SRAM address width.

Ports:
clk  in  1  clock; one clock domain.
rstn  in  1  asynchronous active-low reset.
in_valid  in  1  pixel valid.
in_ready  out  1  pixel accept; accept = in_valid & in_ready.
in_data  in  DW  pixel, raster order.
sram_a  out  AW  SRAM address (column).
sram_wen  out  K  one-hot row-bank write enable, active high.
sram_ren  out  K  row-bank read enable, active high.
sram_d  out  DW  SRAM write data.
sram_q  in  (K-1)*DW  reordered read data, 1-cycle latency.
win_valid  out  1  window valid, single-cycle qualifier.
win_data  out  K*K*DW  window; element (i,j) at [(i*K+j)*DW +: DW].
frame_done  out  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (async assert, sync release): state IDLE, col=row=bank=0; in_ready=1; win_valid=0, frame_done=0, win_data=0; sram_wen=0, sram_ren=0, sram_a=0, sram_d=0.
- SRAM contents are never cleared; FILL rows overwrite stale data before it is used.
- SRAM controls are combinational from the accept.
  - On accept at (row r, col c): sram_a=c, sram_d=in_data, sram_wen=onehot(bank), sram_ren=~sram_wen.
  - bank = r mod K, held in a wrapping counter (no divider).
  - On non-accept cycles: sram_wen=0, sram_ren=0.
- sram_q contract, one cycle after accept: slice j ([(j+1)*DW-1:j*DW], j=0..K-2) = pixel (r-(K-1)+j, c); the top slice is row r-1.
- Counters:
  - col increments per accept; wraps at IMG_W-1 to 0 and increments row.
  - row wraps at IMG_H-1 to 0.
  - bank increments with row; wraps at K-1 to 0, and resets to 0 at frame end.
- Stage 1 (accept+1):
  - Register in_data, col and row as d1 values.
  - Column vector = {in_data_d1, sram_q}; this gives row i = r-(K-1)+i, i=0..K-1.
  - Shift window left: column j takes column j+1, and the new column enters j=K-1.
  - No shift on cycles without a stage-1 accept.
- Stage 2 (accept+2): win_valid=1 iff row_d1>=K-1 and col_d1>=K-1, with win_data = the shifted window. win_data holds its value when win_valid=0.
- Latency: pixel accepted at cycle t produces its window at t+2. There is no output backpressure.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1). No windows straddle a row boundary.
- FSM:
  - IDLE: in_ready=1. Accept of (0,0) -> FILL; if K-1==0 that is illegal, so K>=2 always.
  - FILL: rows 0..K-2; no windows. Accept of (K-1,0) -> RUN.
  - RUN: accept of (IMG_H-1, IMG_W-1) -> DONE.
  - DONE: in_ready=0 for exactly 2 cycles (t+1, t+2). frame_done=1 at t+2 together with the final win_valid. Then -> IDLE at t+3.
- Gaps in in_valid never generate SRAM enables, shifts or windows.
- Reset mid-frame:
  - Immediate return to the reset values above.
  - A pending stage-1/stage-2 window is dropped and no frame_done is issued.
  - The next frame starts at (0,0).

Test Plan:
(K=3, IMG_W=8, IMG_H=6, DW=32, pixel value = row*16+col unless stated.)
1. Continuous stream, in_valid=1 -> first win_valid 2 cycles after accept of (2,2); win_data elements 0..8 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22. Exactly 24 windows; last window top-left is 0x35.
2. Accept of (4,5) -> same cycle sram_a=5, sram_wen=3'b010, sram_ren=3'b101, sram_d=0x45. Idle cycle -> sram_wen=sram_ren=0.
3. Random in_valid bubbles (50%) -> window sequence identical to scenario 1. Every win_valid lands exactly 2 cycles after its accept, and win_data is stable between windows.
4. End of frame: accept (5,7) at t -> in_ready=0 at t+1 and t+2; win_valid=frame_done=1 at t+2 with window 0x35..0x57. A second frame started at t+3 -> its first window is again 0x00..0x22 with correct bank rotation (bank restarts at 0).
5. Assert rstn=0 for 1 cycle after accepting (3,4) -> all outputs at reset values; no frame_done. The restarted frame yields 24 correct windows.
6. K=5, IMG_W=IMG_H=5 -> exactly one window, elements 0..24 = 0x00..0x44 row-major, with frame_done coincident.

Source files
------------

// File: rtl/line_buf_window_gen_if.sv
// rtl/line_buf_window_gen_if.sv - pixel stream, line-buffer SRAM and window bus bundle
interface line_buf_window_gen_if #(
    parameter int KER_SIZE = 3,
    parameter int DW       = 32,
    parameter int AW       = 5
);
    logic                             in_valid;
    logic                             in_ready;
    logic [DW-1:0]                    in_data;
    logic [AW-1:0]                    sram_a;
    logic [KER_SIZE-1:0]              sram_wen;
    logic [KER_SIZE-1:0]              sram_ren;
    logic [DW-1:0]                    sram_d;
    logic [(KER_SIZE-1)*DW-1:0]       sram_q;
    logic                             win_valid;
    logic [KER_SIZE*KER_SIZE*DW-1:0]  win_data;
    logic                             frame_done;

    modport slave (
        input  in_valid, in_data, sram_q,
        output in_ready, sram_a, sram_wen, sram_ren, sram_d, win_valid, win_data, frame_done
    );

    modport master (
        output in_valid, in_data, sram_q,
        input  in_ready, sram_a, sram_wen, sram_ren, sram_d, win_valid, win_data, frame_done
    );
endinterface

// File: rtl/line_buf_window_gen.sv
// rtl/line_buf_window_gen.sv - line-buffer SRAM controller and KxK sliding window generator
module line_buf_window_gen #(
    parameter int KER_SIZE = 3,
    parameter int DW       = 32,
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int AW       = $clog2(IMG_W)
) (
    input  logic                 clk,
    input  logic                 rstn,
    line_buf_window_gen_if.slave bus
);
    localparam int K  = KER_SIZE;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW = $clog2(K);
    localparam int WW = K * K * DW;

    localparam logic [AW-1:0] COL_LAST  = AW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(K - 1);
    localparam logic [AW-1:0] COL_WIN   = AW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            done_cnt_q, done_cnt_d;
    logic [AW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [BW-1:0]   bank_q, bank_d;
    logic            accept, row_end, last_px;
    logic [K-1:0]    bank_oh;

    logic [DW-1:0]   data_d1_q;
    logic [AW-1:0]   col_d1_q;
    logic [RW-1:0]   row_d1_q;
    logic            valid_d1_q, last_d1_q;
    logic [K*DW-1:0] col_vec;
    logic [WW-1:0]   window_q, window_shift;
    logic            win_hit;

    logic            win_valid_q, frame_done_q;
    logic [WW-1:0]   win_data_q;

    assign bus.in_ready = (state_q != DONE);
    assign accept       = bus.in_valid & bus.in_ready;
    assign row_end      = (col_q == COL_LAST);
    assign last_px      = row_end && (row_q == ROW_LAST);
    assign bank_oh      = K'(1) << bank_q;

    // SRAM strobes follow the accept combinationally so the write lands in the accept cycle.
    assign bus.sram_a   = accept ? col_q : '0;
    assign bus.sram_d   = accept ? bus.in_data : '0;
    assign bus.sram_wen = accept ? bank_oh : '0;
    assign bus.sram_ren = accept ? ~bank_oh : '0;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        bank_d = bank_q;
        if (accept) begin
            if (row_end) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d  = '0;
                    bank_d = '0;
                end else begin
                    row_d  = row_q + 1'b1;
                    bank_d = (bank_q == BANK_LAST) ? '0 : bank_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        done_cnt_d = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = FILL;
            FILL: if (accept && row_q == ROW_WIN && col_q == '0) state_d = RUN;
            RUN:  if (accept && last_px) state_d = DONE;
            DONE: begin
                done_cnt_d = 1'b1;
                if (done_cnt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Column vector rows run oldest (top) to newest; the live pixel closes the bottom row.
    assign col_vec = {data_d1_q, bus.sram_q};

    always_comb begin
        window_shift = window_q;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                window_shift[(i*K+j)*DW +: DW] = window_q[(i*K+j+1)*DW +: DW];
            end
            window_shift[(i*K+K-1)*DW +: DW] = col_vec[i*DW +: DW];
        end
    end

    assign win_hit = valid_d1_q && (row_d1_q >= ROW_WIN) && (col_d1_q >= COL_WIN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            done_cnt_q   <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            bank_q       <= '0;
            data_d1_q    <= '0;
            col_d1_q     <= '0;
            row_d1_q     <= '0;
            valid_d1_q   <= 1'b0;
            last_d1_q    <= 1'b0;
            window_q     <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            done_cnt_q   <= done_cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            bank_q       <= bank_d;
            valid_d1_q   <= accept;
            last_d1_q    <= accept && last_px;
            if (accept) begin
                data_d1_q <= bus.in_data;
                col_d1_q  <= col_q;
                row_d1_q  <= row_q;
            end
            if (valid_d1_q) begin
                window_q <= window_shift;
            end
            win_valid_q  <= win_hit;
            frame_done_q <= valid_d1_q && last_d1_q;
            if (win_hit) begin
                win_data_q <= window_shift;
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.win_data   = win_data_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_line_buf_window_gen.sv
// tb/tb_line_buf_window_gen.sv - directed bench for line_buf_window_gen with behavioural SRAM arrays
module tb_line_buf_window_gen;
    localparam int DW  = 32;
    localparam int K3  = 3;
    localparam int W3  = 8;
    localparam int H3  = 6;
    localparam int AW3 = 3;
    localparam int K5  = 5;
    localparam int W5  = 5;
    localparam int H5  = 5;
    localparam int AW5 = 3;
    localparam int WW3 = K3 * K3 * DW;
    localparam int WW5 = K5 * K5 * DW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [WW3-1:0] exp_hold3;

    always #5 clk = ~clk;

    line_buf_window_gen_if #(.KER_SIZE(K3), .DW(DW), .AW(AW3)) b3 ();
    line_buf_window_gen_if #(.KER_SIZE(K5), .DW(DW), .AW(AW5)) b5 ();

    line_buf_window_gen #(.KER_SIZE(K3), .DW(DW), .IMG_W(W3), .IMG_H(H3), .AW(AW3)) dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b3)
    );

    line_buf_window_gen #(.KER_SIZE(K5), .DW(DW), .IMG_W(W5), .IMG_H(H5), .AW(AW5)) dut5 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b5)
    );

    // Behavioural kernel-row arrays: write the active bank, return the other rows oldest first.
    logic [DW-1:0] mem3 [K3][W3];
    logic [DW-1:0] mem5 [K5][W5];

    always @(posedge clk) begin
        for (int b = 0; b < K3; b++) begin
            if (b3.sram_wen[b]) begin
                mem3[b][b3.sram_a] <= b3.sram_d;
                for (int j = 0; j < K3 - 1; j++)
                    b3.sram_q[j*DW +: DW] <= mem3[(b + 1 + j) % K3][b3.sram_a];
            end
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < K5; b++) begin
            if (b5.sram_wen[b]) begin
                mem5[b][b5.sram_a] <= b5.sram_d;
                for (int j = 0; j < K5 - 1; j++)
                    b5.sram_q[j*DW +: DW] <= mem5[(b + 1 + j) % K5][b5.sram_a];
            end
        end
    end

    function automatic logic [WW3-1:0] exp_win3(input int r, input int c);
        logic [WW3-1:0] w;
        for (int i = 0; i < K3; i++)
            for (int j = 0; j < K3; j++)
                w[(i*K3+j)*DW +: DW] = DW'((r - 2 + i) * 16 + (c - 2 + j));
        return w;
    endfunction

    task automatic test_reset();
        b3.in_valid = 1'b0;
        b3.in_data  = '0;
        b5.in_valid = 1'b0;
        b5.in_data  = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({b3.in_ready, b3.win_valid, b3.frame_done, b3.sram_wen, b3.sram_ren, b3.sram_a, b3.sram_d} !==
            {1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_ctrl_k3 got rdy=%0b wv=%0b fd=%0b wen=%b ren=%b a=%0d d=%h exp rdy=1 others 0",
                     b3.in_ready, b3.win_valid, b3.frame_done, b3.sram_wen, b3.sram_ren, b3.sram_a, b3.sram_d);
        end
        total++;
        if (b3.win_data !== '0) begin
            bad++;
            $display("FAIL reset_win_data_k3 got=%h exp=0", b3.win_data);
        end
        total++;
        if ({b5.in_ready, b5.win_valid, b5.frame_done, b5.sram_wen, b5.sram_ren} !=
            {1'b1, 1'b0, 1'b0, 5'b0, 5'b0}) begin
            bad++;
            $display("FAIL reset_ctrl_k5 got rdy=%0b wv=%0b fd=%0b wen=%b ren=%b exp rdy=1 others 0",
                     b5.in_ready, b5.win_valid, b5.frame_done, b5.sram_wen, b5.sram_ren);
        end
        rstn = 1'b1;
        exp_hold3 = '0;
    endtask

    // Streams whole K=3 frames, checking SRAM strobes per cycle and windows at accept+2.
    task automatic run_stream3(input string name, input int frames, input int bubble);
        int r, c, acc, nwin, cyc, npx, done_left;
        logic p1_v, p2_v, p1_last, p2_last, acc_now, rdy_exp, exp_v;
        int p1_r, p1_c, p2_r, p2_c;
        logic [2:0] oh;
        r = 0; c = 0; acc = 0; nwin = 0; done_left = 0;
        p1_v = 1'b0; p2_v = 1'b0; p1_last = 1'b0; p2_last = 1'b0;
        p1_r = 0; p1_c = 0; p2_r = 0; p2_c = 0;
        npx = frames * W3 * H3;
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            exp_v = p2_v && (p2_r >= 2) && (p2_c >= 2);
            total++;
            if (b3.win_valid !== exp_v) begin
                bad++;
                $display("FAIL %s win_valid cyc=%0d got=%0b exp=%0b", name, cyc, b3.win_valid, exp_v);
            end
            total++;
            if (b3.frame_done !== (p2_v && p2_last)) begin
                bad++;
                $display("FAIL %s frame_done cyc=%0d got=%0b exp=%0b", name, cyc, b3.frame_done, p2_v && p2_last);
            end
            if (exp_v) begin
                exp_hold3 = exp_win3(p2_r, p2_c);
                nwin++;
            end
            total++;
            if (b3.win_data !== exp_hold3) begin
                bad++;
                $display("FAIL %s win_data cyc=%0d got=%h exp=%h", name, cyc, b3.win_data, exp_hold3);
            end
            rdy_exp = (done_left == 0);
            total++;
            if (b3.in_ready !== rdy_exp) begin
                bad++;
                $display("FAIL %s in_ready cyc=%0d got=%0b exp=%0b", name, cyc, b3.in_ready, rdy_exp);
            end
            if (acc == npx && !p1_v && !p2_v && done_left == 0) break;
            p2_v = p1_v; p2_r = p1_r; p2_c = p1_c; p2_last = p1_last;
            b3.in_valid = (acc < npx) && (bubble == 0 || $urandom_range(0, 99) >= bubble);
            b3.in_data  = DW'(r * 16 + c);
            acc_now = b3.in_valid && rdy_exp;
            #1;
            oh = 3'(1 << (r % 3));
            if (acc_now) begin
                total++;
                if ({b3.sram_a, b3.sram_wen, b3.sram_ren, b3.sram_d} !== {3'(c), oh, ~oh, DW'(r * 16 + c)}) begin
                    bad++;
                    $display("FAIL %s sram_ctrl r=%0d c=%0d got a=%0d wen=%b ren=%b d=%h exp a=%0d wen=%b ren=%b d=%h",
                             name, r, c, b3.sram_a, b3.sram_wen, b3.sram_ren, b3.sram_d, c, oh, ~oh, r * 16 + c);
                end
            end else begin
                total++;
                if ({b3.sram_wen, b3.sram_ren} !== 6'b0) begin
                    bad++;
                    $display("FAIL %s sram_idle cyc=%0d got wen=%b ren=%b exp 0", name, cyc, b3.sram_wen, b3.sram_ren);
                end
            end
            p1_v = acc_now; p1_r = r; p1_c = c; p1_last = acc_now && (r == H3 - 1) && (c == W3 - 1);
            if (done_left > 0) done_left--;
            if (acc_now) begin
                acc++;
                if (p1_last) done_left = 2;
                if (c == W3 - 1) begin
                    c = 0;
                    r = (r == H3 - 1) ? 0 : r + 1;
                end else begin
                    c++;
                end
            end
        end
        b3.in_valid = 1'b0;
        total++;
        if (acc != npx || p1_v || p2_v) begin
            bad++;
            $display("FAIL %s timeout accepted=%0d exp=%0d", name, acc, npx);
        end
        total++;
        if (nwin != 24 * frames) begin
            bad++;
            $display("FAIL %s window_count got=%0d exp=%0d", name, nwin, 24 * frames);
        end
    endtask

    task automatic test_continuous();
        run_stream3("continuous", 1, 0);
    endtask

    task automatic test_bubbles();
        run_stream3("bubbles", 1, 50);
    endtask

    task automatic test_back_to_back();
        run_stream3("back_to_back", 2, 0);
    endtask

    task automatic test_mid_reset();
        b3.in_valid = 1'b1;
        for (int i = 0; i < 29; i++) begin
            b3.in_data = DW'((i / W3) * 16 + (i % W3));
            @(posedge clk);
            #1;
        end
        b3.in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        total++;
        if ({b3.in_ready, b3.win_valid, b3.frame_done, b3.sram_wen, b3.sram_ren, b3.sram_a, b3.sram_d} !==
            {1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 32'd0}) begin
            bad++;
            $display("FAIL midreset_ctrl got rdy=%0b wv=%0b fd=%0b wen=%b ren=%b a=%0d d=%h exp rdy=1 others 0",
                     b3.in_ready, b3.win_valid, b3.frame_done, b3.sram_wen, b3.sram_ren, b3.sram_a, b3.sram_d);
        end
        total++;
        if (b3.win_data !== '0) begin
            bad++;
            $display("FAIL midreset_win_data got=%h exp=0", b3.win_data);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if ({b3.win_valid, b3.frame_done} !== 2'b00) begin
                bad++;
                $display("FAIL midreset_dropped k=%0d got wv=%0b fd=%0b exp 0 0", k, b3.win_valid, b3.frame_done);
            end
        end
        exp_hold3 = '0;
        run_stream3("after_reset", 1, 0);
    endtask

    task automatic test_k5_single();
        int acc, nwin, last_c;
        logic exp_v;
        logic [WW5-1:0] ew;
        for (int i = 0; i < K5; i++)
            for (int j = 0; j < K5; j++)
                ew[(i*K5+j)*DW +: DW] = DW'(i * 16 + j);
        acc = 0; nwin = 0; last_c = -10;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            exp_v = (cyc == last_c + 2);
            total++;
            if (b5.win_valid !== exp_v) begin
                bad++;
                $display("FAIL k5_win_valid cyc=%0d got=%0b exp=%0b", cyc, b5.win_valid, exp_v);
            end
            total++;
            if (b5.frame_done !== exp_v) begin
                bad++;
                $display("FAIL k5_frame_done cyc=%0d got=%0b exp=%0b", cyc, b5.frame_done, exp_v);
            end
            if (b5.win_valid) begin
                nwin++;
                total++;
                if (b5.win_data !== ew) begin
                    bad++;
                    $display("FAIL k5_win_data got=%h exp=%h", b5.win_data, ew);
                end
            end
            b5.in_valid = (acc < W5 * H5);
            b5.in_data  = DW'((acc / W5) * 16 + (acc % W5));
            if (b5.in_valid) begin
                if (acc == W5 * H5 - 1) last_c = cyc;
                acc++;
            end
        end
        b5.in_valid = 1'b0;
        total++;
        if (nwin != 1) begin
            bad++;
            $display("FAIL k5_window_count got=%0d exp=1", nwin);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_bubbles();
        test_back_to_back();
        test_mid_reset();
        test_k5_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
